// File: rtl/block_serializer_pkg.sv
// Shared definitions for the block serializer and its byte-accumulating bridge.
// Both sides import this package so they agree on widths and byte ordering.
package block_serializer_pkg;

  localparam int BLOCK_W_DEFAULT = 512;
  localparam int BYTE_W_DEFAULT  = 8;
  localparam int NBYTES          = BLOCK_W_DEFAULT / BYTE_W_DEFAULT;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  typedef logic [BYTE_W_DEFAULT-1:0] byte_t;

endpackage

// File: rtl/block_serializer.sv
// Parallel-to-byte serializer: takes one BLOCK_W block and emits it
// most-significant byte first, one byte per out_valid/out_ready handshake.
module block_serializer
  import block_serializer_pkg::*;
#(
  parameter int BLOCK_W = BLOCK_W_DEFAULT,
  parameter int BYTE_W  = BYTE_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [BLOCK_W-1:0] data_in,
  output logic               load_ready,
  output logic [BYTE_W-1:0]  data_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy
);

  localparam int N_BYTES = BLOCK_W / BYTE_W;
  localparam int CNT_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BYTES - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  // Handshakes: a load transfer happens on a rising edge with load && load_ready;
  // a byte transfer happens on a rising edge with out_valid && out_ready.
  // Neither side may retract its offer based on the other's ready.
  logic [0:0]         state;
  logic [BLOCK_W-1:0] sreg;
  logic [CNT_W-1:0]   cnt;

  assign data_out   = sreg[BLOCK_W-1 -: BYTE_W];
  assign out_valid  = (state == S_SEND);
  assign out_last   = (state == S_SEND) && (cnt == CNT_LAST);
  assign busy       = out_valid;
  // Combinational through out_ready so the next block can follow byte 63 with no bubble.
  assign load_ready = (state == S_IDLE) || (out_last && out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      sreg  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load) begin
            sreg  <= data_in;
            cnt   <= '0;
            state <= S_SEND;
          end
        end
        S_SEND: begin
          if (out_ready) begin
            if (out_last) begin
              if (load) begin
                sreg  <= data_in;
                cnt   <= '0;
                state <= S_SEND;
              end else begin
                sreg  <= '0;
                cnt   <= '0;
                state <= S_IDLE;
              end
            end else begin
              sreg <= {sreg[BLOCK_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
              cnt  <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          sreg  <= '0;
        end
      endcase
    end
  end

endmodule
